// File: rtl/collision_detector_multi.sv
//==============================================================================
// Module      : collision_detector_multi
// Description : Frame-level dino/obstacle collision detector that sits beside
//               the VGA scan-out path.
//
//               Each distinct screen pixel that is read is evaluated once. A
//               pixel is a hit when all of the following are true:
//                 - it lies inside the column window,
//                 - the dino pixel is opaque,
//                 - at least one obstacle channel is opaque.
//
//               Hits are counted over one whole frame, from (0,0) to
//               (V_LAST,H_LAST). At the end of the frame, a crash is declared
//               when the count has reached HIT_THRESH. The crash stays latched
//               until a clear pulse, or a reset, releases it.
//
// Ports       : clk          system clock
//               rst          asynchronous reset, active-high
//               enable       game running; low forces the idle state
//               clear        one-cycle pulse that releases a latched crash
//               dino         dino layer pixel
//               obstacle     N_OBS obstacle pixels, channel k = [12k+11:12k]
//               rdn          pixel read strobe, active-low
//               col_addr     current column address
//               row_addr     current row address
//               crash        latched crash flag
//               crash_pulse  one-cycle pulse on entry to the crashed state
//               hit_mask     channels that overlapped in the crash frame
//               overlap_cnt  overlap count of the last completed frame
//
// Config      : COLLIDE_ROW_WINDOW_EN - when defined, a hit also requires
//               TOP <= row_addr <= BOTTOM.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module collision_detector_multi #(
    parameter int          N_OBS      = 3,
    parameter logic [11:0] BG_COLOR   = 12'hfff,
    parameter int          LEFT       = 30,
    parameter int          RIGHT      = 93,
    parameter int          TOP        = 0,
    parameter int          BOTTOM     = 479,
    parameter int          H_LAST     = 639,
    parameter int          V_LAST     = 479,
    parameter int          HIT_THRESH = 4,
    parameter int          CNT_W      = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [11:0]          dino,
    input  logic [12*N_OBS-1:0]  obstacle,
    input  logic                 rdn,
    input  logic [9:0]           col_addr,
    input  logic [8:0]           row_addr,
    output logic                 crash,
    output logic                 crash_pulse,
    output logic [N_OBS-1:0]     hit_mask,
    output logic [CNT_W-1:0]     overlap_cnt
);

    localparam logic [9:0]       c_LEFT    = 10'(LEFT);
    localparam logic [9:0]       c_RIGHT   = 10'(RIGHT);
    localparam logic [9:0]       c_H_LAST  = 10'(H_LAST);
    localparam logic [8:0]       c_V_LAST  = 9'(V_LAST);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_THRESH  = CNT_W'(HIT_THRESH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_CRASHED = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [18:0]        r_last_addr;
    logic               r_rdn_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_OBS-1:0]   r_mask;
    logic               r_crash;
    logic               r_pulse;
    logic [N_OBS-1:0]   r_hit_mask;
    logic [CNT_W-1:0]   r_ovl_cnt;

    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N_OBS-1:0]   w_mask_nxt;
    logic               w_crash_nxt;
    logic               w_pulse_nxt;
    logic [N_OBS-1:0]   w_hit_mask_nxt;
    logic [CNT_W-1:0]   w_ovl_cnt_nxt;

    logic [18:0]        w_addr;
    logic               w_new_px;
    logic               w_col_ok;
    logic               w_row_ok;
    logic               w_px_ok;
    logic [N_OBS-1:0]   w_obs_opaque;
    logic [N_OBS-1:0]   w_hit_bits;
    logic               w_hit;
    logic               w_frame_start;
    logic               w_frame_end;
    logic [CNT_W-1:0]   w_total;
    logic [N_OBS-1:0]   w_mask_acc;

    //--------------------------------------------------------------------------
    // Pixel qualification
    //--------------------------------------------------------------------------
    assign w_addr = {row_addr, col_addr};

    // The address may be held for several clocks when the pixel clock is
    // slower than clk. Only the first clock of each address counts. A fresh
    // falling edge of rdn also counts, so that a re-read of the same address
    // after a strobe gap is seen as a new pixel.
    assign w_new_px = !rdn && ((w_addr != r_last_addr) || r_rdn_d);

    assign w_col_ok = (col_addr >= c_LEFT) && (col_addr <= c_RIGHT);

`ifdef COLLIDE_ROW_WINDOW_EN
    localparam logic [8:0] c_TOP    = 9'(TOP);
    localparam logic [8:0] c_BOTTOM = 9'(BOTTOM);
    assign w_row_ok = (row_addr >= c_TOP) && (row_addr <= c_BOTTOM);
`else
    // The row window is disabled in this build. The parameters are still
    // referenced here, so that a TOP > BOTTOM setting remains visible.
    logic w_unused_row_cfg;
    assign w_unused_row_cfg = (TOP > BOTTOM);
    assign w_row_ok         = 1'b1;
`endif

    for (genvar k = 0; k < N_OBS; k++) begin : g_obs
        assign w_obs_opaque[k] = (obstacle[12*k +: 12] != BG_COLOR);
    end

    assign w_px_ok    = w_new_px && w_col_ok && w_row_ok && (dino != BG_COLOR);
    assign w_hit_bits = w_obs_opaque & {N_OBS{w_px_ok}};
    assign w_hit      = |w_hit_bits;

    assign w_frame_start = w_new_px && (w_addr == 19'd0);
    assign w_frame_end   = w_new_px && (row_addr == c_V_LAST) && (col_addr == c_H_LAST);

    // The running total includes the current pixel, so that the frame_end
    // pixel takes part in its own frame's judgement. The total saturates at
    // the counter's maximum value.
    assign w_total    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(w_hit);
    assign w_mask_acc = r_mask | w_hit_bits;

    //--------------------------------------------------------------------------
    // State and data registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_addr <= '0;
            r_rdn_d     <= 1'b1;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_crash     <= 1'b0;
            r_pulse     <= 1'b0;
            r_hit_mask  <= '0;
            r_ovl_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rdn_d    <= rdn;
            if (!rdn) begin
                r_last_addr <= w_addr;
            end
            r_cnt      <= w_cnt_nxt;
            r_mask     <= w_mask_nxt;
            r_crash    <= w_crash_nxt;
            r_pulse    <= w_pulse_nxt;
            r_hit_mask <= w_hit_mask_nxt;
            r_ovl_cnt  <= w_ovl_cnt_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and next-output logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mask_nxt     = r_mask;
        w_crash_nxt    = r_crash;
        w_pulse_nxt    = 1'b0;
        w_hit_mask_nxt = r_hit_mask;
        w_ovl_cnt_nxt  = r_ovl_cnt;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_mask_nxt = '0;
                // The frame_start pixel is evaluated, so that only complete
                // frames are ever judged.
                if (enable && w_frame_start) begin
                    w_state_nxt = ST_SCAN;
                    w_cnt_nxt   = CNT_W'(w_hit);
                    w_mask_nxt  = w_hit_bits;
                end
            end

            ST_SCAN: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_mask_nxt  = '0;
                end else if (w_frame_end) begin
                    if (w_total >= c_THRESH) begin
                        if (clear) begin
                            // A restart that races the crash takes priority.
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                            w_mask_nxt  = '0;
                        end else begin
                            w_state_nxt    = ST_CRASHED;
                            w_crash_nxt    = 1'b1;
                            w_pulse_nxt    = 1'b1;
                            w_hit_mask_nxt = w_mask_acc;
                            w_ovl_cnt_nxt  = w_total;
                        end
                    end else begin
                        w_ovl_cnt_nxt = w_total;
                        w_cnt_nxt     = '0;
                        w_mask_nxt    = '0;
                    end
                end else begin
                    w_cnt_nxt  = w_total;
                    w_mask_nxt = w_mask_acc;
                end
            end

            ST_CRASHED: begin
                if (clear) begin
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = '0;
                    w_mask_nxt     = '0;
                    w_crash_nxt    = 1'b0;
                    w_hit_mask_nxt = '0;
                    w_ovl_cnt_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign crash       = r_crash;
    assign crash_pulse = r_pulse;
    assign hit_mask    = r_hit_mask;
    assign overlap_cnt = r_ovl_cnt;

endmodule

`default_nettype wire

// File: tb/tb_collision_detector_multi.sv
//==============================================================================
// Module      : tb_collision_detector_multi
// Description : Self-checking bench for collision_detector_multi.
//               - Directed frames carry hand-computed expectations.
//               - Randomized frames are compared, every clock, against a
//                 frame-level behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_collision_detector_multi;

    localparam int          N_OBS = 3;
    localparam int          CNT_W = 10;
    localparam int          THR   = 4;
    localparam int          CMAX  = 1023;

    localparam logic [35:0] OBS_NONE = {12'hfff, 12'hfff, 12'hfff};
    localparam logic [35:0] OBS_CH0  = {12'hfff, 12'hfff, 12'h00f};
    localparam logic [35:0] OBS_CH1  = {12'hfff, 12'h0f0, 12'hfff};
    localparam logic [35:0] OBS_BLK  = {12'h000, 12'h000, 12'h000};
    localparam logic [11:0] DINO     = 12'h123;
    localparam logic [11:0] BG       = 12'hfff;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               clear = 1'b0;
    logic [11:0]        dino = 12'hfff;
    logic [35:0]        obstacle = OBS_NONE;
    logic               rdn = 1'b1;
    logic [9:0]         col_addr = '0;
    logic [8:0]         row_addr = '0;
    logic               crash;
    logic               crash_pulse;
    logic [N_OBS-1:0]   hit_mask;
    logic [CNT_W-1:0]   overlap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    collision_detector_multi dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear       (clear),
        .dino        (dino),
        .obstacle    (obstacle),
        .rdn         (rdn),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .crash       (crash),
        .crash_pulse (crash_pulse),
        .hit_mask    (hit_mask),
        .overlap_cnt (overlap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // Behavioural model.
    // - It tracks which pixels are distinct reads and tallies the frame.
    // - Frames are judged according to the game rules.
    // - `judging` is 1 while a complete frame is being accumulated.
    // - `latched` is 1 while a crash is held.
    //--------------------------------------------------------------------------
    bit         m_judging, m_latched;
    int         m_tally;
    bit [2:0]   m_seen;
    int         m_prev_addr;
    bit         m_prev_rdn;
    bit         e_crash, e_pulse;
    bit [2:0]   e_mask;
    int         e_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_judging = 0; m_latched = 0; m_tally = 0; m_seen = 0;
            m_prev_addr = 0; m_prev_rdn = 1;
            e_crash = 0; e_pulse = 0; e_mask = 0; e_cnt = 0;
        end else begin
            int  addr, total;
            bit  fresh, opaque_px;
            bit [2:0] bits;
            addr      = row_addr * 1024 + col_addr;
            fresh     = !rdn && (addr != m_prev_addr || m_prev_rdn);
            opaque_px = fresh && col_addr >= 30 && col_addr <= 93 && dino != BG;
            for (int k = 0; k < 3; k++)
                bits[k] = opaque_px && (obstacle[12*k +: 12] != BG);
            if (!rdn) m_prev_addr = addr;
            m_prev_rdn = rdn;
            e_pulse = 0;
            total = m_tally + (bits != 0 ? 1 : 0);
            if (total > CMAX) total = CMAX;

            if (m_latched) begin
                if (clear) begin
                    m_latched = 0; e_crash = 0; e_mask = 0; e_cnt = 0;
                end
            end else if (!m_judging) begin
                m_tally = 0; m_seen = 0;
                if (enable && fresh && addr == 0) begin
                    m_judging = 1;
                    m_tally   = (bits != 0) ? 1 : 0;
                    m_seen    = bits;
                end
            end else if (!enable) begin
                m_judging = 0; m_tally = 0; m_seen = 0;
            end else if (fresh && row_addr == 479 && col_addr == 639) begin
                if (total >= THR && clear) begin
                    m_judging = 0; m_tally = 0; m_seen = 0;
                end else if (total >= THR) begin
                    m_judging = 0; m_latched = 1;
                    e_crash = 1; e_pulse = 1; e_mask = m_seen | bits; e_cnt = total;
                end else begin
                    e_cnt = total; m_tally = 0; m_seen = 0;
                end
            end else begin
                m_tally = total;
                m_seen  = m_seen | bits;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("crash",       32'(crash),       32'(e_crash));
            chk("crash_pulse", 32'(crash_pulse), 32'(e_pulse));
            chk("hit_mask",    32'(hit_mask),    32'(e_mask));
            chk("overlap_cnt", 32'(overlap_cnt), 32'(e_cnt));
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers. Every helper is called, and returns, at a negedge.
    //--------------------------------------------------------------------------
    task automatic px(input int r, input int c, input logic [11:0] d,
                      input logic [35:0] o, input int hold, input bit clr);
        row_addr = 9'(r); col_addr = 10'(c); dino = d; obstacle = o;
        rdn = 1'b0; clear = clr;
        @(negedge clk);
        clear = 1'b0;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic gap(input int n);
        rdn = 1'b1; clear = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic fstart();
        px(0, 0, BG, OBS_NONE, 1, 1'b0);
    endtask

    task automatic fend(input bit clr);
        px(479, 639, BG, OBS_NONE, 1, clr);
    endtask

    task automatic hits(input int row, input int col0, input int n,
                        input logic [35:0] o, input int hold);
        for (int i = 0; i < n; i++) px(row, col0 + i, DINO, o, hold, 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1; rdn = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset crash", 32'(crash), 32'd0);
        chk("reset cnt",   32'(overlap_cnt), 32'd0);
        rst = 1'b0;
        enable = 1'b1;
        gap(2);

        // Threshold frame: 4 hits on channel 1.
        fstart(); hits(10, 40, 4, OBS_CH1, 1); fend(1'b0);
        chk("thr crash",  32'(crash), 32'd1);
        chk("thr pulse",  32'(crash_pulse), 32'd1);
        chk("thr mask",   32'(hit_mask), 32'b010);
        chk("thr cnt",    32'(overlap_cnt), 32'd4);
        gap(1);
        chk("pulse one clk", 32'(crash_pulse), 32'd0);
        enable = 1'b0;
        gap(3);
        chk("enable0 holds crash", 32'(crash), 32'd1);
        enable = 1'b1;
        pulse_clear();
        chk("clear crash", 32'(crash), 32'd0);
        chk("clear mask",  32'(hit_mask), 32'd0);
        chk("clear cnt",   32'(overlap_cnt), 32'd0);

        // Below threshold, then an empty frame.
        fstart(); hits(20, 50, 3, OBS_CH0, 1); fend(1'b0);
        chk("below crash", 32'(crash), 32'd0);
        chk("below cnt",   32'(overlap_cnt), 32'd3);
        fstart(); fend(1'b0);
        chk("empty cnt",   32'(overlap_cnt), 32'd0);

        // Window and background edges.
        fstart();
        px(10, 29, DINO, OBS_CH0, 1, 1'b0);
        px(10, 94, DINO, OBS_CH0, 1, 1'b0);
        px(11, 50, BG,   OBS_BLK, 1, 1'b0);
        px(12, 30, DINO, OBS_CH0, 1, 1'b0);
        px(12, 93, DINO, OBS_CH0, 1, 1'b0);
        fend(1'b0);
        chk("window cnt", 32'(overlap_cnt), 32'd2);

        // Slow pixel clock: each address held for 4 clocks.
        fstart(); hits(200, 60, 4, OBS_CH0, 4); fend(1'b0);
        chk("slow cnt",  32'(overlap_cnt), 32'd4);
        chk("slow mask", 32'(hit_mask), 32'b001);
        pulse_clear();

        // A clear that races a qualifying frame_end wins.
        fstart(); hits(30, 40, 4, OBS_CH1, 1); fend(1'b1);
        chk("race crash", 32'(crash), 32'd0);
        chk("race pulse", 32'(crash_pulse), 32'd0);
        // Now idle: a frame without (0,0) is not judged.
        hits(40, 40, 5, OBS_CH1, 1); fend(1'b0);
        chk("race idle crash", 32'(crash), 32'd0);

        // Reset mid-frame.
        fstart(); hits(50, 40, 3, OBS_CH0, 1); fend(1'b0);
        fstart(); hits(60, 40, 3, OBS_CH0, 1);
        rst = 1'b1;
        #1;
        chk("rst crash", 32'(crash), 32'd0);
        chk("rst mask",  32'(hit_mask), 32'd0);
        chk("rst cnt",   32'(overlap_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hits(61, 40, 5, OBS_CH0, 1); fend(1'b0);
        chk("post-rst partial", 32'(crash), 32'd0);
        fstart(); hits(70, 40, 5, {12'h001, 12'hfff, 12'h002}, 1); fend(1'b0);
        chk("post-rst crash", 32'(crash), 32'd1);
        chk("post-rst mask",  32'(hit_mask), 32'b101);
        chk("post-rst cnt",   32'(overlap_cnt), 32'd5);
        pulse_clear();

        // Counter saturation: 17 rows x 64 columns = 1088 hits.
        fstart();
        for (int r = 1; r <= 17; r++) hits(r, 30, 64, OBS_CH0, 1);
        fend(1'b0);
        chk("sat cnt", 32'(overlap_cnt), 32'd1023);
        pulse_clear();

        // Randomized frames.
        for (int f = 0; f < 150; f++) begin
            int np;
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 7) != 0) fstart();
            np = $urandom_range(0, 8);
            for (int p = 0; p < np; p++) begin
                logic [35:0] o;
                logic [11:0] d;
                for (int k = 0; k < 3; k++)
                    o[12*k +: 12] = ($urandom_range(0, 2) == 0) ? 12'($urandom) : BG;
                d = ($urandom_range(0, 3) == 0) ? BG : 12'($urandom);
                px($urandom_range(1, 478), $urandom_range(25, 98), d, o,
                   $urandom_range(1, 3), $urandom_range(0, 29) == 0);
                if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
                if ($urandom_range(0, 40) == 0) enable = ~enable;
            end
            fend($urandom_range(0, 5) == 0);
            gap($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) pulse_clear();
        end

        gap(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
